// File: rtl/pc_stack.sv
// Program counter with relative/absolute branching and a hardware return-address
// stack; overflow/underflow are latched into sticky flags until cleared.
module pc_stack #(
    parameter int AW    = 16,
    parameter int OW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_in,
    input  logic [2:0]    pc_ctrl,
    input  logic [OW-1:0] offset_addr,
    input  logic [AW-1:0] target,
    input  logic          err_clr,
    output logic [AW-1:0] pc_out,
    output logic          stk_full,
    output logic          stk_empty,
    output logic          stk_ovf,
    output logic          stk_unf
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    logic [AW-1:0] pc_r;
    logic [AW-1:0] stk_r [DEPTH];
    logic [CW-1:0] count_r;
    logic          ovf_r;
    logic          unf_r;

    logic [AW-1:0] pc_inc_s;
    logic [AW-1:0] pc_br_s;
    logic [AW-1:0] top_s;
    logic [IW-1:0] wr_idx_s;
    logic [IW-1:0] rd_idx_s;
    logic          full_s;
    logic          empty_s;
    logic [AW-1:0] pc_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic          push_s;
    logic          ovf_set_s;
    logic          unf_set_s;

    assign full_s   = (count_r == CW'(DEPTH));
    assign empty_s  = (count_r == {CW{1'b0}});
    assign pc_inc_s = pc_r + AW'(1);
    assign pc_br_s  = pc_r + AW'($signed(offset_addr));
    // Index truncation is harmless: writes are blocked when full, reads when empty.
    assign wr_idx_s = IW'(count_r);
    assign rd_idx_s = IW'(count_r - CW'(1));
    assign top_s    = stk_r[rd_idx_s];

    // Next-state decode of the requested operation.
    always_comb begin
        pc_nxt_s    = pc_r;
        count_nxt_s = count_r;
        push_s      = 1'b0;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        if (en_in) begin
            case (pc_ctrl)
                OP_HOLD: pc_nxt_s = pc_r;
                OP_INC:  pc_nxt_s = pc_inc_s;
                OP_JMP:  pc_nxt_s = target;
                OP_BR:   pc_nxt_s = pc_br_s;
                OP_CALL: begin
                    if (full_s) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        push_s      = 1'b1;
                        count_nxt_s = count_r + CW'(1);
                        pc_nxt_s    = target;
                    end
                end
                OP_RET: begin
                    if (empty_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        count_nxt_s = count_r - CW'(1);
                        pc_nxt_s    = top_s;
                    end
                end
                default: pc_nxt_s = pc_r;
            endcase
        end else begin
            pc_nxt_s    = pc_r;
            count_nxt_s = count_r;
        end
    end

    // PC, stack depth and sticky error flags; a new error wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            count_r <= count_nxt_s;
            ovf_r   <= ovf_set_s | (ovf_r & ~err_clr);
            unf_r   <= unf_set_s | (unf_r & ~err_clr);
        end
    end

    // Return-address storage; CALL pushes the address after the call site.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stk_r[i] <= {AW{1'b0}};
            end
        end else if (push_s) begin
            stk_r[wr_idx_s] <= pc_inc_s;
        end
    end

    assign pc_out    = pc_r;
    assign stk_full  = full_s;
    assign stk_empty = empty_s;
    assign stk_ovf   = ovf_r;
    assign stk_unf   = unf_r;

endmodule
